// File: rtl/html_stream_controller_pkg.sv
// Shared constants and state encoding for the HTML character stream controller.
package html_stream_controller_pkg;

    localparam int unsigned CHAR_BITS = 8;

    localparam logic [CHAR_BITS-1:0] NEWLINE = 8'h0A;
    localparam logic [CHAR_BITS-1:0] NUL     = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/html_stream_controller_if.sv
// Reader request/response link plus the positioned character output stream.
interface html_stream_controller_if
    import html_stream_controller_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = CHAR_BITS,
    parameter int unsigned POS_WIDTH  = 16
);

    logic                  rd_rewind;
    logic                  rd_req;
    logic                  rd_valid;
    logic [CHAR_WIDTH-1:0] rd_char;
    logic                  rd_eof;

    logic                  out_valid;
    logic                  out_ready;
    logic [CHAR_WIDTH-1:0] out_char;
    logic                  out_last;
    logic [POS_WIDTH-1:0]  out_line;
    logic [POS_WIDTH-1:0]  out_col;

    modport master (
        output rd_rewind, rd_req,
        input  rd_valid, rd_char, rd_eof,
        output out_valid, out_char, out_last, out_line, out_col,
        input  out_ready
    );

    modport slave (
        input  rd_rewind, rd_req,
        output rd_valid, rd_char, rd_eof,
        input  out_valid, out_char, out_last, out_line, out_col,
        output out_ready
    );

endinterface

// File: rtl/html_stream_controller_fifo.sv
// Small synchronous FIFO; the producer's credit scheme keeps it from overflowing.
module stream_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [WIDTH-1:0]       o_head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero when empty so the stream outputs read 0 after reset.
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/html_stream_controller.sv
// Sequences reader requests, tags characters with line/column and emits a NUL end beat.
module html_stream_controller
    import html_stream_controller_pkg::*;
#(
    parameter int unsigned CHAR_WIDTH = CHAR_BITS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POS_WIDTH  = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    html_stream_controller_if.master bus
);

    localparam int unsigned ENTRY_W = 1 + CHAR_WIDTH + 2 * POS_WIDTH;
    localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;

    state_t r_state;
    state_t w_next_state;

    logic                 r_rewind;
    logic                 r_inflight;
    logic                 r_eof_seen;
    logic                 r_busy;
    logic                 r_done;
    logic [POS_WIDTH-1:0] r_line;
    logic [POS_WIDTH-1:0] r_col;

    logic                 w_start_ok;
    logic                 w_rd_req;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_head_last;
    logic [CW-1:0]        w_count;
    logic [CW:0]          w_used;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_head;

    always_comb begin
        w_start_ok  = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
        w_used      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
        w_rd_req    = (r_state == ST_RUN) && !r_rewind && !r_eof_seen
                      && (w_used < (CW+1)'(FIFO_DEPTH));
        // Responses only count while a request is outstanding and the document is open.
        w_accept    = bus.rd_valid && r_inflight && (r_state == ST_RUN) && !r_eof_seen;
        w_push_data = {bus.rd_eof, (bus.rd_eof ? CHAR_WIDTH'(NUL) : bus.rd_char), r_line, r_col};
        w_pop       = (w_count != '0) && bus.out_ready;
        w_head_last = w_head[ENTRY_W-1];
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_next_state = ST_RUN;
            ST_RUN:   if (w_accept && bus.rd_eof) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_pop && w_head_last) w_next_state = ST_DONE;
            ST_DONE:  if (w_start_ok) w_next_state = ST_RUN;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == ST_RUN) || (w_next_state == ST_DRAIN);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rewind   <= 1'b0;
            r_inflight <= 1'b0;
            r_eof_seen <= 1'b0;
            r_line     <= POS_WIDTH'(1);
            r_col      <= POS_WIDTH'(1);
        end else begin
            r_rewind   <= w_start_ok;
            r_inflight <= w_rd_req;
            if (w_start_ok) begin
                r_eof_seen <= 1'b0;
                r_line     <= POS_WIDTH'(1);
                r_col      <= POS_WIDTH'(1);
            end else if (w_accept) begin
                if (bus.rd_eof) begin
                    r_eof_seen <= 1'b1;
                end else if (bus.rd_char == CHAR_WIDTH'(NEWLINE)) begin
                    r_line <= (r_line == '1) ? r_line : r_line + 1'b1;
                    r_col  <= POS_WIDTH'(1);
                end else begin
                    r_col  <= (r_col == '1) ? r_col : r_col + 1'b1;
                end
            end
        end
    end

    stream_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_push      (w_accept),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign bus.rd_rewind = r_rewind;
    assign bus.rd_req    = w_rd_req;
    assign bus.out_valid = (w_count != '0);
    assign {bus.out_last, bus.out_char, bus.out_line, bus.out_col} = w_head;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_html_stream_controller.sv
// Bench: reader model, table of documents, scoreboard of expected beats, corner-case sequences.
module tb_html_stream_controller;

    typedef struct packed {
        logic        last;
        logic [7:0]  ch;
        logic [15:0] line;
        logic [15:0] col;
    } beat_t;

    typedef struct {
        string       text;
        int unsigned stall;
        int unsigned beats;
        int unsigned end_line;
        int unsigned end_col;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, start4;
    logic busy, done, busy4, done4;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0]  file_q[$];
    int unsigned rd_ptr = 0;
    beat_t       exp_q[$];
    int unsigned beats = 0;
    logic [15:0] last_line, last_col;
    logic        mon_en = 1'b0;
    logic        inject = 1'b0;
    logic        hold_low = 1'b0;
    int unsigned stall = 0;
    int unsigned cyc = 0;
    logic [40:0] head;
    logic [40:0] prev_head;
    logic        prev_stall = 1'b0;
    logic        done_pending = 1'b0;

    html_stream_controller_if #(.CHAR_WIDTH(8), .POS_WIDTH(16)) bus ();
    html_stream_controller_if #(.CHAR_WIDTH(8), .POS_WIDTH(4))  bus4 ();

    html_stream_controller #(.CHAR_WIDTH(8), .FIFO_DEPTH(4), .POS_WIDTH(16)) u_dut (
        .i_clock (clk), .i_reset (rst), .i_start (start),
        .o_busy  (busy), .o_done (done), .bus (bus)
    );

    html_stream_controller #(.CHAR_WIDTH(8), .FIFO_DEPTH(4), .POS_WIDTH(4)) u_dut4 (
        .i_clock (clk), .i_reset (rst), .i_start (start4),
        .o_busy  (busy4), .o_done (done4), .bus (bus4)
    );

    always #5 clk = ~clk;

    assign head = {bus.out_last, bus.out_char, bus.out_line, bus.out_col};

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Reader: answers each request one cycle later, EOF past the end of the file.
    initial begin
        logic pend_req, pend_inj;
        bus.rd_valid = 1'b0;
        bus.rd_char  = '0;
        bus.rd_eof   = 1'b0;
        forever begin
            @(negedge clk);
            pend_req = bus.rd_req;
            pend_inj = inject;
            if (bus.rd_rewind) rd_ptr = 0;
            @(posedge clk);
            #1;
            bus.rd_valid = pend_req || pend_inj;
            bus.rd_eof   = 1'b0;
            bus.rd_char  = '0;
            if (pend_inj) begin
                bus.rd_char = 8'h5A;
            end else if (pend_req) begin
                if (rd_ptr < file_q.size()) begin
                    bus.rd_char = file_q[rd_ptr];
                    rd_ptr++;
                end else begin
                    bus.rd_eof = 1'b1;
                end
            end
        end
    end

    initial begin
        logic r4;
        bus4.rd_valid  = 1'b0;
        bus4.rd_char   = '0;
        bus4.rd_eof    = 1'b0;
        bus4.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            r4 = bus4.rd_req;
            @(posedge clk);
            #1;
            bus4.rd_valid = r4;
            bus4.rd_char  = 8'h78;
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.out_ready = hold_low ? 1'b0 : ((stall == 0) ? 1'b1 : ((cyc % stall) != 0));
        end
    end

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_stall   = 1'b0;
            done_pending = 1'b0;
        end else begin
            if (done_pending) begin
                check("done_after_last", {busy, done}, 2'b01);
                done_pending = 1'b0;
            end
            if (prev_stall) check("head_hold", {bus.out_valid, head}, {1'b1, prev_head});
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%h required=none", head);
                end else begin
                    check("beat", head, exp_q.pop_front());
                    beats++;
                    if (bus.out_last) begin
                        last_line    = bus.out_line;
                        last_col     = bus.out_col;
                        done_pending = 1'b1;
                        check("last_pop_state", {busy, done}, 2'b10);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_head  = head;
        end
    end

    task automatic begin_doc(input string txt);
        logic [15:0] l, c;
        logic [7:0]  ch;
        file_q.delete();
        exp_q.delete();
        beats = 0;
        l = 16'd1;
        c = 16'd1;
        for (int i = 0; i < txt.len(); i++) begin
            ch = txt[i];
            file_q.push_back(ch);
            exp_q.push_back({1'b0, ch, l, c});
            if (ch == 8'h0A) begin
                l = (l == 16'hFFFF) ? l : l + 16'd1;
                c = 16'd1;
            end else begin
                c = (c == 16'hFFFF) ? c : c + 16'd1;
            end
        end
        exp_q.push_back({1'b1, 8'h00, l, c});
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("rewind_cycle", {bus.rd_rewind, bus.rd_req, busy, done}, 4'b1010);
        @(posedge clk); #1;
        check("first_req", {bus.rd_rewind, bus.rd_req}, 2'b01);
        @(posedge clk); #1;
        check("no_valid_yet", bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check("first_valid", bus.out_valid, 1'b1);
    endtask

    task automatic wait_doc(input int unsigned nbeats, input int unsigned eline, input int unsigned ecol);
        for (int n = 0; n < 600 && !done; n++) @(negedge clk);
        check("doc_done", {busy, done}, 2'b01);
        check("beat_count", beats, nbeats);
        check("end_pos", {last_line, last_col}, {16'(eline), 16'(ecol)});
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int unsigned n4;
        tbl[0] = '{"ab\nc", 0, 5, 2, 2};
        tbl[1] = '{"", 0, 1, 1, 1};
        tbl[2] = '{"hello\nworld\n\nx", 3, 15, 4, 2};
        tbl[3] = '{"\n\n", 2, 3, 3, 1};

        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.rd_rewind, bus.rd_req, bus.out_valid, bus.out_last, busy, done,
                              bus.out_char, bus.out_line, bus.out_col}, '0);
        check("reset_state4", {bus4.rd_req, bus4.out_valid, busy4, done4}, '0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Column saturation at 4-bit positions: 20 characters, no newline.
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        n4 = 0;
        for (int c = 0; c < 200 && n4 < 20; c++) begin
            @(negedge clk);
            if (bus4.out_valid) begin
                check("sat_col", {bus4.out_line, bus4.out_col}, {4'd1, 4'((n4 + 1 > 15) ? 15 : n4 + 1)});
                n4++;
            end
        end
        check("sat_count", n4, 20);

        for (int i = 0; i < 4; i++) begin
            stall = tbl[i].stall;
            begin_doc(tbl[i].text);
            wait_doc(tbl[i].beats, tbl[i].end_line, tbl[i].end_col);
        end

        // Backpressure: credit must stop requests at four outstanding characters.
        stall = 0;
        hold_low = 1'b1;
        begin_doc("0123456789ABCDEF");
        repeat (10) @(posedge clk);
        #1;
        check("bp_req_stopped", bus.rd_req, 1'b0);
        check("bp_served", rd_ptr, 4);
        check("bp_valid", bus.out_valid, 1'b1);
        hold_low = 1'b0;
        wait_doc(17, 1, 17);

        // Reset mid-document with a request in flight.
        begin_doc("abcdefgh");
        for (int c = 0; c < 100 && beats < 3; c++) @(negedge clk);
        mon_en = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_outputs", {bus.rd_rewind, bus.rd_req, bus.out_valid, bus.out_last, busy, done,
                                    bus.out_char, bus.out_line, bus.out_col}, '0);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", {bus.out_valid, busy, done, bus.rd_req}, '0);
        inject = 1'b1;
        @(negedge clk); #1 inject = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("spurious_dropped", {bus.out_valid, busy}, 2'b00);
        begin_doc("abcdefgh");
        wait_doc(9, 1, 9);

        // start while busy is ignored; start from DONE replays the document.
        stall = 2;
        begin_doc("xyz\nw");
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("start_ignored", {busy, bus.rd_rewind}, 2'b10);
        wait_doc(6, 2, 2);
        begin_doc("xyz\nw");
        wait_doc(6, 2, 2);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/html_stream_controller.md
# html_stream_controller

Sequences the raw HTML character source for the parser front end. Drives the reader with a one-request/one-response protocol and buffers characters in a small FIFO. Presents them downstream on a valid/ready stream, each character tagged with its line/column position. Terminates the document with an explicit NUL end beat.

## Interface
- CHAR_WIDTH, 8, character width; equals the shared char-bits width.
- FIFO_DEPTH, 4, buffer entries; power of two, ≥2.
- POS_WIDTH, 16, width of line/column counters.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; begins a document pass (accepted in IDLE or DONE only).
- rd_rewind  out  1  one-cycle pulse telling the reader to reopen/rewind its file.
- rd_req  out  1  request next character.
- rd_valid  in  1  reader response, exactly one cycle after rd_req.
- rd_char  in  CHAR_WIDTH  character, valid with rd_valid.
- rd_eof  in  1  with rd_valid: end of file; rd_char ignored.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts.
- out_char  out  CHAR_WIDTH  character (0x00 on end beat).
- out_last  out  1  end-of-document beat.
- out_line, out_col  out  POS_WIDTH  1-based position of out_char.
- busy  out  1  in RUN or DRAIN.
- done  out  1  in DONE.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset → IDLE; all outputs 0; FIFO empty; line=col=1.
- IDLE/DONE + start → RUN: rd_rewind=1 for the first RUN cycle; line=col=1; eof_seen=0. start in RUN/DRAIN is ignored.
- rd_req = RUN ∧ ¬rewind_cycle ∧ ¬eof_seen ∧ (count + inflight < FIFO_DEPTH). inflight = rd_req of the previous cycle. Credit guarantees a response never finds the FIFO full.
- rd_valid ∧ ¬rd_eof: push {last=0, rd_char, line, col}. If rd_char==0x0A: line+1, col=1. Otherwise col+1.
- rd_valid ∧ rd_eof: push {last=1, 0x00, line, col}; eof_seen=1; → DRAIN.
- rd_valid with no outstanding request (inflight=0) is discarded.
- Counters saturate at all-ones and do not wrap.
- Pop on out_valid ∧ out_ready. Push and pop in the same cycle are allowed; count is unchanged.
- DRAIN: when the last=1 entry is popped → DONE. done holds until start or reset.
- out_* reflect the FIFO head. out_valid = count>0. The head must not change while out_valid ∧ ¬out_ready.
- Empty file: a single beat {0x00, last=1, line 1, col 1}.

## Timing
- start sampled at edge E0 → rd_rewind high E0–E1 → rd_req high E1–E2 → rd_valid sampled E3 → out_valid high after E3. Latency from start edge to first out_valid: 3 cycles.
- Steady state with out_ready=1: one character per cycle.
- Reset mid-operation: at the next edge, all state returns to reset values and the FIFO is flushed. rd_req is 0 from that cycle. A reader response to a pre-reset request arrives during reset and is dropped.
- busy and done are registered from state and are never high together.

## Structure
- Shared package/defines: CHAR_WIDTH default (char-bits width), NEWLINE=0x0A, NUL=0x00, state encodings.
- Sub-module stream_fifo: synchronous FIFO, width 1+CHAR_WIDTH+2·POS_WIDTH, depth FIFO_DEPTH. Ports: push, pop, count, head; no overflow logic, since the controller's credit rule prevents overflow.
- Controller: FSM, credit/inflight tracking, position counters.

## Test plan
- File "ab\nc", out_ready=1 → beats a(1,1), b(1,2), 0x0A(1,3), c(2,1), 0x00 last(2,2). done rises the cycle after the last pop.
- Empty file → one beat 0x00, last=1, (1,1); then DONE.
- out_ready=0 for 10 cycles, FIFO_DEPTH=4 → rd_req stops once count+inflight=4. After release, all characters arrive in order with none lost or duplicated.
- Reset after 3 characters are emitted and one request is inflight → all outputs 0 next cycle; late rd_valid ignored. The next start restarts from the first character at (1,1).
- start pulsed while busy → no effect. start in DONE → rd_rewind pulse, positions restart at (1,1), identical second pass.
- POS_WIDTH=4, 20 characters without a newline → out_col saturates at 15; line stays 1.
